pipe_stage_reg: RTL and testbench

Generic, parametrised inter-stage pipeline register for the 32I pipeline, replacing hand-written per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a control bundle and a data bundle from producer stage to consumer stage under a valid/ready handshake. It supports hazard stall, branch/jump flush with bubble insertion, and an optional two-entry skid buffer that keeps full throughput while registering `in_ready`.

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/pipe_slot.sv | 42 ++++
 rtl/pipe_stage_reg.sv | 175 +++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the 32I inter-stage pipeline registers.
// Occupancy state encoding, default bubble control value and per-stage
// bundle widths for IF/ID, ID/EX, EX/MEM and MEM/WB.
package pipe_pkg;

  // Occupancy of a pipeline stage register; the encoding equals the entry count.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_e;

  // Bubble control: no memory access, no register write, no jump.
  localparam logic [15:0] CTRL_NOP_DEFAULT = 16'h0000;

  // Per-stage bundle widths.
  localparam int IFID_CTRL_W  = 16;
  localparam int IFID_DATA_W  = 96;   // pc, pc4, inst
  localparam int IDEX_CTRL_W  = 16;
  localparam int IDEX_DATA_W  = 224;  // pc, pc4, inst, imm, rs1, rs2, rd/misc
  localparam int EXMEM_CTRL_W = 16;
  localparam int EXMEM_DATA_W = 128;  // pc4, alu result, store data, rd/misc
  localparam int MEMWB_CTRL_W = 16;
  localparam int MEMWB_DATA_W = 128;  // pc4, alu result, load data, rd/misc

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one storage slot of a pipeline stage register (control + data).
// load captures a new entry; clear_ctrl forces the control field to the
// bubble value while the data field keeps its contents.
module pipe_slot #(
  parameter int                 CTRL_W   = 16,
  parameter int                 DATA_W   = 224,
  parameter logic [CTRL_W-1:0]  CTRL_NOP = {CTRL_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear_ctrl,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data
);

  logic [CTRL_W-1:0] ctrl_r;
  logic [DATA_W-1:0] data_r;

  // Slot storage: clearing the control field has priority over loading it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_r <= CTRL_NOP;
      data_r <= {DATA_W{1'b0}};
    end else begin
      if (clear_ctrl) begin
        ctrl_r <= CTRL_NOP;
      end else if (load) begin
        ctrl_r <= d_ctrl;
      end
      if (load) begin
        data_r <= d_data;
      end
    end
  end

  assign q_ctrl = ctrl_r;
  assign q_data = data_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic valid/ready inter-stage pipeline register with
// stall, flush (bubble insertion) and an optional two-entry skid buffer.
// Build option: define PIPE_STAGE_SKID_EN for the two-entry skid variant
// with a registered in_ready; otherwise a single slot is used.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                CTRL_W   = 16,
  parameter int                DATA_W   = 224,
  parameter logic [CTRL_W-1:0] CTRL_NOP = CTRL_W'(CTRL_NOP_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

  occ_state_e        state_r;
  occ_state_e        state_s;
  logic              valid_r;
  logic              space_s;
  logic              accept_s;
  logic              release_s;
  logic              main_load_s;
  logic              main_clear_s;
  logic [CTRL_W-1:0] main_d_ctrl_s;
  logic [DATA_W-1:0] main_d_data_s;

`ifdef PIPE_STAGE_SKID_EN
  logic              ready_r;
  logic              skid_load_s;
  logic              main_sel_skid_s;
  logic [CTRL_W-1:0] skid_ctrl_s;
  logic [DATA_W-1:0] skid_data_s;

  // Space is registered so out_ready never reaches in_ready combinationally.
  assign space_s = ready_r;
`else
  // Single slot: room when empty or when the held entry leaves this cycle.
  assign space_s = !valid_r || out_ready;
`endif

  assign in_ready  = !stall && !flush && space_s;
  assign accept_s  = in_valid && in_ready;
  assign release_s = valid_r && out_ready;

  // Occupancy next-state and slot load control; flush empties from any state.
  always_comb begin
    state_s     = state_r;
    main_load_s = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    skid_load_s     = 1'b0;
    main_sel_skid_s = 1'b0;
`endif
    if (flush) begin
      state_s = OCC_EMPTY;
    end else begin
      case (state_r)
        OCC_EMPTY: begin
          if (accept_s) begin
            state_s     = OCC_ONE;
            main_load_s = 1'b1;
          end else begin
            state_s = OCC_EMPTY;
          end
        end
        OCC_ONE: begin
          if (accept_s && release_s) begin
            state_s     = OCC_ONE;
            main_load_s = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
          end else if (accept_s) begin
            state_s     = OCC_FULL;
            skid_load_s = 1'b1;
`endif
          end else if (release_s) begin
            state_s = OCC_EMPTY;
          end else begin
            state_s = OCC_ONE;
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        OCC_FULL: begin
          if (release_s) begin
            state_s         = OCC_ONE;
            main_load_s     = 1'b1;
            main_sel_skid_s = 1'b1;
          end else begin
            state_s = OCC_FULL;
          end
        end
`endif
        default: begin
          state_s = OCC_EMPTY;
        end
      endcase
    end
  end

  // Outputs show a bubble control value whenever the stage will be empty.
  assign main_clear_s = (state_s == OCC_EMPTY);

`ifdef PIPE_STAGE_SKID_EN
  assign main_d_ctrl_s = main_sel_skid_s ? skid_ctrl_s : in_ctrl;
  assign main_d_data_s = main_sel_skid_s ? skid_data_s : in_data;
`else
  assign main_d_ctrl_s = in_ctrl;
  assign main_d_data_s = in_data;
`endif

  // Occupancy state and output-valid flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= OCC_EMPTY;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_s;
      valid_r <= (state_s != OCC_EMPTY);
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  // Registered space flag: accept allowed next cycle unless both slots are held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_r <= 1'b1;
    end else begin
      ready_r <= (state_s != OCC_FULL);
    end
  end

  pipe_slot #(
    .CTRL_W   (CTRL_W),
    .DATA_W   (DATA_W),
    .CTRL_NOP (CTRL_NOP)
  ) u_skid (
    .clk        (clk),
    .reset      (reset),
    .load       (skid_load_s),
    .clear_ctrl (flush),
    .d_ctrl     (in_ctrl),
    .d_data     (in_data),
    .q_ctrl     (skid_ctrl_s),
    .q_data     (skid_data_s)
  );
`endif

  pipe_slot #(
    .CTRL_W   (CTRL_W),
    .DATA_W   (DATA_W),
    .CTRL_NOP (CTRL_NOP)
  ) u_main (
    .clk        (clk),
    .reset      (reset),
    .load       (main_load_s),
    .clear_ctrl (main_clear_s),
    .d_ctrl     (main_d_ctrl_s),
    .d_data     (main_d_data_s),
    .q_ctrl     (out_ctrl),
    .q_data     (out_data)
  );

  assign out_valid = valid_r;
  assign occ       = state_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: self-checking bench for pipe_stage_reg. A queue-based
// reference model (capacity 2 with PIPE_STAGE_SKID_EN, else 1) predicts
// in_ready, out_* and occ under directed and random stimulus.
module tb_pipe_stage_reg;

  localparam int CW = 16;
  localparam int DW = 224;
  localparam logic [CW-1:0] NOP = 16'h0000;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic          clk;
  logic          reset;
  logic          stall;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occ;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CTRL_NOP(NOP)) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occ       (occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: FIFO of held entries plus the last data shown.
  logic [CW-1:0] m_ctrl[$];
  logic [DW-1:0] m_data[$];
  logic [DW-1:0] m_last;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic ev;
    ev = (m_ctrl.size() > 0);
    chk("out_valid", DW'(out_valid), DW'(ev));
    chk("out_ctrl", DW'(out_ctrl), ev ? DW'(m_ctrl[0]) : DW'(NOP));
    chk("out_data", out_data, ev ? m_data[0] : m_last);
    chk("occ", DW'(occ), DW'(m_ctrl.size()));
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    r = {DW{1'b0}};
    for (int k = 0; k < 7; k++) r = {r[DW-33:0], 32'($urandom)};
    return r;
  endfunction

  // One clock cycle: drive, check in_ready, clock, update model, check outputs.
  task automatic step(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                      input logic ordy, input logic stl, input logic fl);
    logic exp_rdy;
    logic acc;
    logic rel;
    @(negedge clk);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    stall     = stl;
    flush     = fl;
    #1;
    if (CAP == 2) exp_rdy = !stl && !fl && (m_ctrl.size() < 2);
    else          exp_rdy = !stl && !fl && (m_ctrl.size() == 0 || ordy);
    chk("in_ready", DW'(in_ready), DW'(exp_rdy));
    acc = v && exp_rdy;
    rel = (m_ctrl.size() > 0) && ordy;
    @(posedge clk);
    #1;
    if (rel) begin
      void'(m_ctrl.pop_front());
      void'(m_data.pop_front());
    end
    if (fl) begin
      m_ctrl.delete();
      m_data.delete();
    end
    if (acc) begin
      m_ctrl.push_back(c);
      m_data.push_back(d);
    end
    if (m_ctrl.size() > 0) m_last = m_data[0];
    check_outputs();
  endtask

  // Reset asserted between edges; outputs must clear before any clock edge.
  task automatic mid_reset();
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    m_ctrl.delete();
    m_data.delete();
    m_last = {DW{1'b0}};
    check_outputs();
    in_valid  = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("in_ready_after_reset", DW'(in_ready), DW'(1'b1));
  endtask

  initial begin
    reset     = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_ctrl   = {CW{1'b0}};
    in_data   = {DW{1'b0}};
    out_ready = 1'b0;
    m_last    = {DW{1'b0}};
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("in_ready_after_reset", DW'(in_ready), DW'(1'b1));

    // First entry and a gap-free stream.
    step(1'b1, 16'h00A5, DW'(32'hA5A5), 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) step(1'b1, CW'(i), DW'(i), 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0000, DW'(0), 1'b1, 1'b0, 1'b0);

    // Back-pressure: three offered with out_ready low, then drain in order.
    for (int i = 1; i <= 3; i++) step(1'b1, CW'(16'h0100 + i), DW'(100 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, DW'(0), 1'b1, 1'b0, 1'b0);

    // Stall with one entry held: drain, then a bubble keeping the last data.
    step(1'b1, 16'h0201, DW'(32'h0000_1000), 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0202, DW'(32'h0000_1004), 1'b1, 1'b1, 1'b0);
    step(1'b1, 16'h0203, DW'(32'h0000_1008), 1'b1, 1'b1, 1'b0);

    // Flush with the stage filled and an input offered in the same cycle.
    step(1'b1, 16'h0301, DW'(301), 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0302, DW'(302), 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0303, DW'(303), 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'h0000, DW'(0), 1'b1, 1'b0, 1'b0);

    // Release and flush together.
    step(1'b1, 16'h0401, DW'(401), 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0402, DW'(402), 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0000, DW'(0), 1'b1, 1'b0, 1'b1);

    // Asynchronous reset mid-stream with the stage filled.
    step(1'b1, 16'h0501, DW'(501), 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0502, DW'(502), 1'b0, 1'b0, 1'b0);
    mid_reset();
    step(1'b1, 16'h0601, DW'(601), 1'b1, 1'b0, 1'b0);

    // Toggling out_ready with a continuous offer.
    for (int i = 0; i < 4; i++) step(1'b1, CW'(16'h0700 + i), DW'(700 + i), (i % 2) == 0, 1'b0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, CW'($urandom) | 16'h0001, rand_data(),
           $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
